// File: rtl/slc3_branch_unit.sv
// SLC-3 branch unit: resolves BR, JMP/RET and JSR/JSRR from the latched NZP flags.
// Runs a four-state start/done sequence and keeps a saturating count of taken transfers.
module slc3_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [15:0]      IR,
  input  logic [15:0]      PC,
  input  logic [2:0]       NZP,
  input  logic [15:0]      BaseR,
  input  logic             ClearCount,
  output logic             Busy,
  output logic             Done,
  output logic             BEN,
  output logic             Redirect,
  output logic [15:0]      TargetPC,
  output logic             LD_R7,
  output logic [15:0]      R7Value,
  output logic             Illegal,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {IDLE, EVAL, TARGET, COMMIT} state_t;

  state_t      state, state_next;
  logic [15:0] ir_q, pc_q, base_q;
  logic [2:0]  nzp_q;
  logic        ben_q, illegal_q;
  logic [15:0] target_q, r7_q;
  logic        ben_calc, illegal_calc;
  logic [15:0] target_calc;
  logic [3:0]  opcode;
  logic        is_br, is_jsr, is_jmp;

  assign opcode = ir_q[15:12];
  assign is_br  = (opcode == 4'b0000);
  assign is_jsr = (opcode == 4'b0100);
  assign is_jmp = (opcode == 4'b1100);

  // Decision and target are derived only from the captured operands.
  always_comb begin
    ben_calc     = 1'b0;
    illegal_calc = 1'b0;
    target_calc  = pc_q;
    if (is_br) begin
      ben_calc    = |(ir_q[11:9] & nzp_q);
      target_calc = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
    end else if (is_jsr) begin
      ben_calc    = 1'b1;
      target_calc = ir_q[11] ? (pc_q + {{5{ir_q[10]}}, ir_q[10:0]}) : base_q;
    end else if (is_jmp) begin
      ben_calc    = 1'b1;
      target_calc = base_q;
    end else begin
      illegal_calc = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = EVAL;
      EVAL:    state_next = TARGET;
      TARGET:  state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ir_q      <= '0;
      pc_q      <= '0;
      nzp_q     <= '0;
      base_q    <= '0;
      ben_q     <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
      r7_q      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && Start) begin
        ir_q   <= IR;
        pc_q   <= PC;
        nzp_q  <= NZP;
        base_q <= BaseR;
      end
      if (state == EVAL) begin
        ben_q     <= ben_calc;
        illegal_q <= illegal_calc;
      end
      if (state == TARGET) begin
        target_q <= target_calc;
        r7_q     <= pc_q;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)
      TakenCount <= '0;
    else if (ClearCount)
      TakenCount <= '0;
    else if (Redirect && (TakenCount != '1))
      TakenCount <= TakenCount + CNT_W'(1);
  end

  // BEN and the target become visible combinationally in their own state, then hold.
  assign Busy     = (state != IDLE);
  assign Done     = (state == COMMIT);
  assign Redirect = Done & ben_q;
  assign LD_R7    = Done & is_jsr;
  assign Illegal  = Done & illegal_q;
  assign BEN      = (state == EVAL)   ? ben_calc    : ben_q;
  assign TargetPC = (state == TARGET) ? target_calc : target_q;
  assign R7Value  = (state == TARGET) ? pc_q        : r7_q;

endmodule

// File: tb/tb_slc3_branch_unit.sv
// Self-checking bench for slc3_branch_unit: directed cases plus random transfers
// checked against an opcode-level reference model.
module tb_slc3_branch_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Start = 1'b0;
  logic [15:0]      IR = '0, PC = '0, BaseR = '0;
  logic [2:0]       NZP = '0;
  logic             ClearCount = 1'b0;
  logic             Busy, Done, BEN, Redirect, LD_R7, Illegal;
  logic [15:0]      TargetPC, R7Value;
  logic [CNT_W-1:0] TakenCount;

  int compared = 0;
  int mismatched = 0;
  int cntModel = 0;

  slc3_branch_unit #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .IR(IR), .PC(PC), .NZP(NZP),
    .BaseR(BaseR), .ClearCount(ClearCount), .Busy(Busy), .Done(Done), .BEN(BEN),
    .Redirect(Redirect), .TargetPC(TargetPC), .LD_R7(LD_R7), .R7Value(R7Value),
    .Illegal(Illegal), .TakenCount(TakenCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Opcode-level model: offsets as signed integers, sums taken modulo 65536.
  task automatic refModel(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                          input logic [15:0] base, output logic ben, output logic [15:0] tgt,
                          output logic ld, output logic ill);
    int off, sum;
    int op;
    op  = int'(ir[15:12]);
    ben = 1'b0; ld = 1'b0; ill = 1'b0; tgt = pc;
    if (op == 0) begin
      ben = ((ir[11] && nzp[2]) || (ir[10] && nzp[1]) || (ir[9] && nzp[0]));
      off = int'(ir[8:0]);
      if (off >= 256) off -= 512;
      sum = int'(pc) + off;
      tgt = sum[15:0];
    end else if (op == 4) begin
      ben = 1'b1; ld = 1'b1;
      if (ir[11]) begin
        off = int'(ir[10:0]);
        if (off >= 1024) off -= 2048;
        sum = int'(pc) + off;
        tgt = sum[15:0];
      end else begin
        tgt = base;
      end
    end else if (op == 12) begin
      ben = 1'b1; tgt = base;
    end else begin
      ill = 1'b1;
    end
  endtask

  // Runs one request from IDLE through the following IDLE cycle, scrambling inputs after acceptance.
  task automatic applyStimulus(input logic [15:0] ir, input logic [15:0] pc, input logic [2:0] nzp,
                               input logic [15:0] base, input bit holdStart, input bit clr);
    logic eBen, eLd, eIll;
    logic [15:0] eTgt;
    refModel(ir, pc, nzp, base, eBen, eTgt, eLd, eIll);
    IR = ir; PC = pc; NZP = nzp; BaseR = base; Start = 1'b1;
    @(posedge Clk); #1;
    if (!holdStart) Start = 1'b0;
    IR = 16'($urandom); PC = 16'($urandom); NZP = 3'($urandom); BaseR = 16'($urandom);
    checkOutput("busy_eval", Busy, 1);
    checkOutput("done_eval", Done, 0);
    checkOutput("ben_eval", BEN, eBen);
    @(posedge Clk); #1;
    checkOutput("target_tgt", TargetPC, eTgt);
    checkOutput("done_tgt", Done, 0);
    @(posedge Clk); #1;
    checkOutput("done_commit", Done, 1);
    checkOutput("redirect", Redirect, eBen);
    checkOutput("ld_r7", LD_R7, eLd);
    checkOutput("illegal", Illegal, eIll);
    checkOutput("r7value", R7Value, pc);
    checkOutput("target_commit", TargetPC, eTgt);
    if (clr) ClearCount = 1'b1;
    if (clr) cntModel = 0;
    else if (eBen && cntModel < CNT_MAX) cntModel++;
    @(posedge Clk); #1;
    ClearCount = 1'b0;
    Start = 1'b0;
    checkOutput("done_idle", Done, 0);
    checkOutput("busy_idle", Busy, 0);
    checkOutput("ben_hold", BEN, eBen);
    checkOutput("count", TakenCount, cntModel);
    if (holdStart) begin
      @(posedge Clk); #1;
      checkOutput("no_requeue_busy", Busy, 0);
      checkOutput("no_requeue_done", Done, 0);
    end
  endtask

  initial begin
    logic [15:0] rir;
    int pick;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_target", TargetPC, 0);
    checkOutput("rst_count", TakenCount, 0);
    Reset = 1'b0;

    applyStimulus(16'h0405, 16'h3001, 3'b010, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h09FE, 16'h3010, 3'b001, 16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h4BFF, 16'h0000, 3'b100, 16'h5555, 1'b0, 1'b0);
    applyStimulus(16'hC1C0, 16'h2000, 3'b000, 16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h0E05, 16'h2000, 3'b000, 16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h2000, 3'b111, 16'h1234, 1'b0, 1'b0);
    applyStimulus(16'h41C0, 16'h4000, 3'b010, 16'hBEEF, 1'b0, 1'b0);
    applyStimulus(16'h1261, 16'h3000, 3'b010, 16'h0000, 1'b1, 1'b0);

    // Abort a JSR while in TARGET.
    IR = 16'h4805; PC = 16'h3000; NZP = 3'b001; BaseR = 16'h0000; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_done", Done, 0);
    checkOutput("abort_ld_r7", LD_R7, 0);
    checkOutput("abort_target", TargetPC, 0);
    checkOutput("abort_r7", R7Value, 0);
    checkOutput("abort_count", TakenCount, 0);
    cntModel = 0;
    @(posedge Clk); #1;
    checkOutput("abort_no_done", Done, 0);
    Reset = 1'b0;
    applyStimulus(16'h4805, 16'h3000, 3'b001, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      rir  = 16'($urandom);
      pick = int'($urandom_range(0, 4));
      if (pick <= 1) rir[15:12] = 4'b0000;
      else if (pick == 2) rir[15:12] = 4'b0100;
      else if (pick == 3) rir[15:12] = 4'b1100;
      applyStimulus(rir, 16'($urandom), 3'($urandom), 16'($urandom),
                    1'($urandom_range(0, 7) == 0), $urandom_range(0, 24) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
